// File: rtl/jtframe_db15_resp.sv
// jtframe_db15_resp
// Device-side responder of the DB15 serial joystick link. It emulates the
// parallel-in/serial-out shift chain of a DB15 adapter. Two 16-bit joystick
// words are captured while the reader holds JOY_LOAD low. They are shifted
// out on JOY_DATA, LSB of joy1 first, on each rising edge of JOY_CLK.
//
// Ports
//   clk_sys     system clock
//   rst         asynchronous active-high reset
//   joy1, joy2  joystick states, active-high (1 = pressed)
//   JOY_CLK     reader shift clock, asynchronous, shift on rising edge
//   JOY_LOAD    reader parallel load, asynchronous, active-low
//   JOY_DATA    serial data, active-low buttons, registered
//   frame_done  one-cycle pulse after the 32nd shift
//   bit_cnt     shifts since last load, saturates at 32
//   overrun     sticky, a shift edge arrived with bit_cnt already at 32
//   link_ok     reader activity present
//
// Configuration
//   JTFRAME_DB15_WDOG_EN  defined: link_ok is driven by a WDOG_W-bit watchdog
//                         that is cleared on each falling edge of JOY_LOAD.
//                         undefined: link_ok is 1 whenever not in reset.

module jtframe_db15_resp #(
    parameter int unsigned WDOG_W = 20
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic [15:0] joy1,
    input  logic [15:0] joy2,
    input  logic        JOY_CLK,
    input  logic        JOY_LOAD,
    output logic        JOY_DATA,
    output logic        frame_done,
    output logic [5:0]  bit_cnt,
    output logic        overrun,
    output logic        link_ok
);

    // [1:0] synchronizer, [2] aligned level, [3] previous level for edges.
    // Both pins go through identical pipelines, so the simultaneous-event
    // rules hold between the reader's load and clock pins.
    // The reset value is all ones. With that value, an idle-high pin creates
    // no edge after reset, and neither does an idle-low clock.
    logic [3:0]  clk_sh;
    logic [3:0]  load_sh;
    logic [31:0] sr;

    logic load_lvl;
    logic load_rise;
    logic clk_rise;
    logic shift_en;
    logic frame_full;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            clk_sh  <= '1;
            load_sh <= '1;
        end else begin
            clk_sh  <= {clk_sh[2:0], JOY_CLK};
            load_sh <= {load_sh[2:0], JOY_LOAD};
        end
    end

    assign load_lvl   = load_sh[2];
    assign load_rise  = load_sh[2] & ~load_sh[3];
    assign clk_rise   = clk_sh[2] & ~clk_sh[3];
    // A clock edge arriving together with the load release is dropped.
    assign shift_en   = load_lvl & clk_rise & ~load_rise;
    assign frame_full = (bit_cnt == 6'd32);

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            sr         <= '1;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!load_lvl) begin
                sr      <= {~joy2, ~joy1};
                bit_cnt <= '0;
            end else if (shift_en) begin
                if (frame_full) begin
                    overrun <= 1'b1;
                end else begin
                    sr      <= {1'b1, sr[31:1]};
                    bit_cnt <= bit_cnt + 6'd1;
                    if (bit_cnt == 6'd31) frame_done <= 1'b1;
                end
            end
        end
    end

    assign JOY_DATA = sr[0];

`ifdef JTFRAME_DB15_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

    logic [WDOG_W-1:0] wdog_cnt;
    logic              load_fall;

    assign load_fall = ~load_sh[2] & load_sh[3];

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
            link_ok  <= 1'b0;
        end else if (load_fall) begin
            wdog_cnt <= '0;
            link_ok  <= 1'b1;
        end else if (wdog_cnt != '1) begin
            wdog_cnt <= wdog_cnt + 1'b1;
            // link drops on the same edge the counter saturates
            if (wdog_cnt == WDOG_LAST) link_ok <= 1'b0;
        end else begin
            link_ok <= 1'b0;
        end
    end
`else
    // Without the watchdog, the link is reported up whenever out of reset.
    // WDOG_W is a positive width, so the expression below is always 1.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) link_ok <= 1'b0;
        else     link_ok <= (WDOG_W > 0);
    end
`endif

endmodule

// File: tb/tb_jtframe_db15_resp.sv
module tb_jtframe_db15_resp;

    logic        clk_sys = 1'b0;
    logic        rst     = 1'b1;
    logic [15:0] joy1    = '0;
    logic [15:0] joy2    = '0;
    logic        JOY_CLK  = 1'b0;
    logic        JOY_LOAD = 1'b1;
    logic        JOY_DATA;
    logic        frame_done;
    logic [5:0]  bit_cnt;
    logic        overrun;
    logic        link_ok;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_cnt  = 0;
    logic exp_q[$];

    jtframe_db15_resp #(.WDOG_W(8)) dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .joy1       (joy1),
        .joy2       (joy2),
        .JOY_CLK    (JOY_CLK),
        .JOY_LOAD   (JOY_LOAD),
        .JOY_DATA   (JOY_DATA),
        .frame_done (frame_done),
        .bit_cnt    (bit_cnt),
        .overrun    (overrun),
        .link_ok    (link_ok)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) if (frame_done) fd_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "time limit");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected serial order: joy1[0..15] then joy2[0..15], active-low
    task automatic push_frame();
        for (int i = 0; i < 16; i++) exp_q.push_back(~joy1[i]);
        for (int i = 0; i < 16; i++) exp_q.push_back(~joy2[i]);
    endtask

    task automatic pop_bit(input string tag);
        logic e;
        n_tests++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected a pending bit", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(tag, {31'd0, JOY_DATA}, {31'd0, e});
        end
    endtask

    task automatic do_load(input int lo);
        JOY_LOAD = 1'b0;
        tick(lo);
        JOY_LOAD = 1'b1;
        push_frame();
        tick(6);
    endtask

    task automatic pulse();
        JOY_CLK = 1'b1;
        tick(4);
        JOY_CLK = 1'b0;
        tick(4);
    endtask

    // reads bit0, shifts 31 times, then checks the 32nd edge in detail
    task automatic read_frame(input string tag);
        int fd0;
        pop_bit({tag, "_bit0"});
        for (int k = 1; k < 32; k++) begin
            pulse();
            pop_bit($sformatf("%s_bit%0d", tag, k));
        end
        fd0 = fd_cnt;
        JOY_CLK = 1'b1;
        tick(3);
        chk({tag, "_fd_early"}, {31'd0, frame_done}, 32'd0);
        tick(1);
        chk({tag, "_fd_pulse"}, {31'd0, frame_done}, 32'd1);
        tick(1);
        chk({tag, "_fd_end"}, {31'd0, frame_done}, 32'd0);
        JOY_CLK = 1'b0;
        tick(4);
        chk({tag, "_fd_once"}, fd_cnt - fd0, 32'd1);
        chk({tag, "_data_end"}, {31'd0, JOY_DATA}, 32'd1);
        chk({tag, "_cnt32"}, {26'd0, bit_cnt}, 32'd32);
    endtask

    initial begin
        // reset values
        tick(3);
        chk("rst_data", {31'd0, JOY_DATA}, 32'd1);
        chk("rst_cnt", {26'd0, bit_cnt}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        chk("rst_link", {31'd0, link_ok}, 32'd0);
        rst = 1'b0;
        tick(1);
`ifdef JTFRAME_DB15_WDOG_EN
        chk("link_pre_load", {31'd0, link_ok}, 32'd0);
        JOY_LOAD = 1'b0;
        tick(5);
        chk("link_first_load", {31'd0, link_ok}, 32'd1);
        JOY_LOAD = 1'b1;
        tick(200);
        chk("link_held", {31'd0, link_ok}, 32'd1);
        tick(100);
        chk("link_timeout", {31'd0, link_ok}, 32'd0);
        JOY_LOAD = 1'b0;
        tick(5);
        chk("link_restored", {31'd0, link_ok}, 32'd1);
        JOY_LOAD = 1'b1;
        tick(6);
`else
        chk("link_after_rst", {31'd0, link_ok}, 32'd1);
`endif

        // frame A: single pressed bits at both ends
        joy1 = 16'h0001;
        joy2 = 16'h8000;
        do_load(4);
        chk("a_cnt0", {26'd0, bit_cnt}, 32'd0);
        read_frame("a");
        chk("a_ovr_clear", {31'd0, overrun}, 32'd0);

        // 33rd edge
        pulse();
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        chk("ovr_data", {31'd0, JOY_DATA}, 32'd1);
        chk("ovr_cnt", {26'd0, bit_cnt}, 32'd32);

        // clocks during load, input change during load, and a clock edge
        // that coincides with load release
        joy1 = 16'h00FF;
        joy2 = 16'($urandom);
        JOY_LOAD = 1'b0;
        tick(2);
        for (int p = 0; p < 5; p++) begin
            if (p == 2) joy1 = 16'hFF00;
            pulse();
            chk($sformatf("ld_cnt_p%0d", p), {26'd0, bit_cnt}, 32'd0);
        end
        JOY_LOAD = 1'b1;
        JOY_CLK  = 1'b1;
        push_frame();
        tick(6);
        chk("sim_noshift", {26'd0, bit_cnt}, 32'd0);
        JOY_CLK = 1'b0;
        tick(4);
        read_frame("b");
        chk("ovr_persist", {31'd0, overrun}, 32'd1);

        // reset in the middle of a frame
        joy1 = 16'($urandom);
        joy2 = 16'($urandom);
        do_load(3);
        pop_bit("c_bit0");
        for (int k = 1; k <= 10; k++) begin
            pulse();
            pop_bit($sformatf("c_bit%0d", k));
        end
        chk("c_cnt10", {26'd0, bit_cnt}, 32'd10);
        rst = 1'b1;
        #1;
        chk("mid_rst_data", {31'd0, JOY_DATA}, 32'd1);
        chk("mid_rst_cnt", {26'd0, bit_cnt}, 32'd0);
        chk("mid_rst_ovr", {31'd0, overrun}, 32'd0);
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        tick(2);

        joy1 = 16'hA5C3;
        joy2 = 16'h3C5A;
        do_load(3);
        joy1 = 16'hFFFF;   // changes during shift must not reach this frame
        joy2 = 16'h0000;
        read_frame("d");
        chk("d_ovr", {31'd0, overrun}, 32'd0);

`ifndef JTFRAME_DB15_WDOG_EN
        tick(300);
        chk("link_idle", {31'd0, link_ok}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtframe_db15_resp.md
# jtframe_db15_resp

Responder (device-side) end of the DB15 serial joystick link. The block emulates the parallel-in/serial-out shift chain of a DB15 adapter. It captures two 16-bit joystick words and shifts them out on `JOY_DATA` under control of an external reader driving `JOY_CLK`/`JOY_LOAD`. It serves as the bench model for the MiSTer DB15 reader and as the adapter core when a JTFRAME board acts as controller source.

## Interface
Parameters:
- `WDOG_W`, 20: link-watchdog counter width; timeout after 2^WDOG_W−1 `clk_sys` cycles without a frame start.

Ports:
- `clk_sys`  in  1  system clock (48 MHz nominal)
- `rst`  in  1  reset, asynchronous, active-high
- `joy1`  in  16  joystick 1 state, active-high (1 = pressed)
- `joy2`  in  16  joystick 2 state, active-high
- `JOY_CLK`  in  1  shift clock from reader, asynchronous; shift on rising edge
- `JOY_LOAD`  in  1  parallel load from reader, asynchronous, active-low
- `JOY_DATA`  out  1  serial data, active-low buttons, registered
- `frame_done`  out  1  one-cycle pulse after the 32nd shift
- `bit_cnt`  out  6  shifts since last load, saturates at 32
- `overrun`  out  1  sticky; shift edge seen with `bit_cnt`==32
- `link_ok`  out  1  reader activity present

## Operation
- `JOY_CLK` and `JOY_LOAD` each pass through a 2-flop synchronizer, then a 1-flop edge register. Only the synchronized versions are used.
- The shift register `sr` is 32 bits and holds {~joy2, ~joy1}. `JOY_DATA` = `sr[0]`.
- Frame order: joy1[0] first, then up to joy1[15], then joy2[0] up to joy2[15].
- LOAD phase: while synchronized `JOY_LOAD`=0, `sr` reloads from the inputs every cycle and `bit_cnt`=0. Clock edges are ignored.
- SHIFT phase: when `JOY_LOAD`=1 and a rising edge of synchronized `JOY_CLK` occurs:
  - `sr` <= {1'b1, sr[31:1]};
  - `bit_cnt` increments.
  - On the transition 31→32, `frame_done` pulses.
- END phase: when `bit_cnt`=32, `sr` is all ones and `JOY_DATA`=1. Any further rising edge sets `overrun` and leaves `bit_cnt` at 32.
- Simultaneous events:
  - Load low in the same cycle as a clock edge: load wins.
  - Load rising and a clock edge in the same cycle: no shift, so the first shift needs a later edge.
- Watchdog:
  - Each falling edge of synchronized `JOY_LOAD` clears the counter and sets `link_ok`=1.
  - Otherwise the counter increments and saturates at all ones, at which point `link_ok`=0.
- Reset mid-frame: all state returns to its reset values immediately. The next valid frame starts at the next LOAD low.

## Timing
- Reset values:
  - `JOY_DATA`=1, `sr`=32'hFFFF_FFFF
  - `frame_done`=0, `bit_cnt`=0, `overrun`=0
  - `link_ok`=0, watchdog counter=0
- Latency:
  - Pin edge of `JOY_CLK` to updated `JOY_DATA`: 4 `clk_sys` cycles (2 sync + 1 edge + 1 output register).
  - `JOY_LOAD` low to the first bit valid: 4 cycles.
- Reader constraints:
  - `JOY_CLK` high and low times ≥ 4 `clk_sys` cycles each.
  - The reader samples `JOY_DATA` at least 5 cycles after a load or shift edge.
  - `JOY_LOAD` low pulse ≥ 3 cycles.
- Input capture: `joy1`/`joy2` are sampled continuously during the LOAD phase. The last LOAD-phase cycle defines the frame contents. Input changes during SHIFT do not affect the frame in flight.

## Configuration
- `JTFRAME_DB15_WDOG_EN`: defined → the watchdog counter and `link_ok` behave as described above.
- Not defined → no counter is synthesized and `link_ok` is tied to 1 after reset deassertion (0 during reset).

## Test plan
- Reset asserted mid-shift at `bit_cnt`=10 → next cycle `JOY_DATA`=1, `bit_cnt`=0, `overrun`=0. The following load/32 shifts deliver the correct frame.
- joy1=16'h0001, joy2=16'h8000, LOAD pulse, then 32 clocks at 8-cycle period → serial stream:
  - bit0=0, bits1–30=1, bit31=0;
  - `frame_done` pulses once, 4 cycles after the 32nd edge;
  - `bit_cnt`=32.
- 33 clocks after a load → the 33rd edge sets `overrun`=1 and `JOY_DATA` stays 1. `overrun` persists through the next frame until reset.
- LOAD held low while 5 `JOY_CLK` edges occur, joy1 changing 16'h00FF→16'hFF00 during the low phase → `bit_cnt`=0 throughout, and the first 8 bits out = 1 (reflecting 16'hFF00).
- With `JTFRAME_DB15_WDOG_EN`, WDOG_W=8:
  - `link_ok`=1 after the first load;
  - with no load for 255 cycles, `link_ok`=0;
  - the next load edge restores 1.
- Without the macro: `link_ok`=1 one cycle after reset release, regardless of activity.
